sec_pipe_locked: RTL
====================

# sec_pipe_locked

Parametrised, pipelined single-error-correcting (SEC) decoder. It generalises the team's combinational 32-bit SEC benchmark to any data width and check width, and adds a valid/ready stream interface, a 2-stage pipeline, a serially loaded lock key, and error statistics counters. It is the sequential benchmark target for key-recovery experiments. Outputs are functionally correct only when the loaded key equals `KEY_MASK`.

## Interface
- `DATA_W`, 32: data bits per word (4..64).
- `CHK_W`, 6: check bits. Must satisfy 2^CHK_W − CHK_W − 1 ≥ DATA_W.
- `KEY_MASK`, 6'h2D: correct key value, CHK_W bits wide.
- `CNT_W`, 16: width of the statistics counters.
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input word valid.
- `in_ready`, out, 1: block can accept a word.
- `in_data`, in, DATA_W: received data.
- `in_chk`, in, CHK_W: received check bits.
- `in_en`, in, 1: correction enable (c499 N137 role). When 0, data passes through uncorrected.
- `out_valid`, out, 1: output word valid.
- `out_ready`, in, 1: downstream accepts the word.
- `out_data`, out, DATA_W: corrected data.
- `out_corr`, out, 1: a data bit was flipped.
- `out_chkerr`, out, 1: single check-bit error; data is unchanged.
- `out_unc`, out, 1: nonzero syndrome that matches no column.
- `key_shift`, in, 1: shift `key_sin` into the key register this cycle.
- `key_sin`, in, 1: serial key bit, LSB first. The new bit enters at the MSB and the register shifts right.
- `corr_cnt`, out, CNT_W: saturating count of `out_corr` words.
- `unc_cnt`, out, CNT_W: saturating count of `out_unc` words.
- `cnt_clr`, in, 1: synchronous clear of both counters.

## Operation
- H column for data bit j: the (j+1)-th value in the ascending sequence 3,5,6,7,9,10,…, i.e. the values with popcount ≥ 2.
- Stage 1, on accept: compute raw syndrome s = in_chk XOR (XOR over j of in_data[j]·col[j]). Register data, s and en.
- Stage 2, on advance: compute es = s XOR key_reg XOR KEY_MASK, using key_reg at that cycle. Then:
  - en = 0 or es = 0: data unchanged, all flags 0.
  - es == col[j]: flip bit j, set out_corr.
  - es is a power of two: set out_chkerr, data unchanged.
  - Otherwise: set out_unc, data unchanged.
- Flags are mutually exclusive.
- Key register: CHK_W bits, reset value 0. It is not gated by pipeline state. A key update mid-stream affects every word advancing to stage 2 afterwards.
- Counters:
  - Increment once per output handshake (out_valid & out_ready) carrying the matching flag.
  - Saturate at 2^CNT_W − 1.
  - cnt_clr has priority over increment in the same cycle.

## Timing
- Reset values: out_valid = 0, out_data = 0, all flags 0, corr_cnt = unc_cnt = 0, key_reg = 0, stage-1 valid = 0.
- in_ready is 1 from the first cycle after reset.
- Latency: a word accepted at edge k appears on out_* after edge k+2, provided out_ready stays high.
- Throughput: 1 word per cycle.
- Stage 1 advances when stage 2 is empty or is emptying this cycle.
- in_ready = !s1_valid | s1_advance. This is combinational from out_ready; at most one pipeline bubble is allowed.
- Output holds: while out_valid & !out_ready, out_data and the flags are held stable.
- Full pipeline with out_ready = 0: in_ready = 0 and no word is lost or duplicated.
- rst_n asserted mid-stream: in-flight words are discarded immediately and asynchronously. No output handshake may occur in the reset cycle.

## Test plan
1. Reset, then load key 0x2D (6 shifts). Stream 1000 random words with 0 errors, out_ready = 1. Required: out_data == in_data, zero flags, latency 2, counters 0.
2. Correct key; flip data bit 17 of word 0xDEADBEEF (valid chk). Required: out_data = 0xDEADBEEF, out_corr = 1, corr_cnt = 1.
3. Correct key; flip in_chk[3]. Required: out_chkerr = 1, data unchanged. Flip data bits 0 and 1 (es = 3^5 = 6 = col[2]). Required: data bit 2 miscorrected, out_corr = 1. This documents SEC-only behaviour.
4. Key 0: error-free word gives es = 0x2D. Required: out_unc = 1 (0x2D is not a column), unc_cnt increments. in_en = 0 gives a pass-through with no flags.
5. Backpressure: out_ready toggles 1,0,0,1 with a continuous input stream. Required: in_ready low while full, output held stable, order preserved, no loss.
6. Counter saturation with CNT_W = 4: 20 corrected words, with cnt_clr asserted together with the 20th. Required: the counter stops at 15, then reads 0 after the clear.

Source files
------------

// File: rtl/sec_pipe_locked_if.sv
// Stream bundle for the locked SEC decoder: received word in, corrected word out.
// No storage; pure wiring between producer, decoder and consumer.
// Backpressure carried by in_ready (from decoder) and out_ready (from consumer).
interface sec_pipe_locked_if #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              in_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_corr;
  logic              out_chkerr;
  logic              out_unc;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_chk, in_en, out_ready,
    input  in_ready, out_valid, out_data, out_corr, out_chkerr, out_unc
  );

  // Decoder side
  modport slave (
    input  in_valid, in_data, in_chk, in_en, out_ready,
    output in_ready, out_valid, out_data, out_corr, out_chkerr, out_unc
  );
endinterface

// File: rtl/sec_pipe_locked.sv
// Key-locked pipelined SEC decoder with serial key load and saturating error counters.
// Latency: word driven in cycle k is captured at the next edge and shows on out_* after the second edge.
// Backpressure: in_ready = !s1_valid | s1_advance (combinational from out_ready); output held while stalled.
module sec_pipe_locked #(
  parameter int               DATA_W   = 32,
  parameter int               CHK_W    = 6,
  parameter logic [CHK_W-1:0] KEY_MASK = 6'h2D,
  parameter int               CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sec_pipe_locked_if.slave     bus,
  input  logic                 key_shift,
  input  logic                 key_sin,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     unc_cnt
);

  typedef logic [DATA_W*CHK_W-1:0] col_tab_t;

  // Data-bit columns are the ascending values with at least two bits set,
  // so they never collide with zero or with a single check-bit position.
  function automatic col_tab_t gen_cols();
    col_tab_t t = '0;
    int       v = 3;
    for (int j = 0; j < DATA_W; j++) begin
      while ($countones(v) < 2) v++;
      t[j*CHK_W +: CHK_W] = v[CHK_W-1:0];
      v++;
    end
    return t;
  endfunction

  localparam col_tab_t COLS = gen_cols();

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  syn;
    logic              en;
  } s1_t;

  logic              s1_valid;
  s1_t               s1_q;
  logic [CHK_W-1:0]  in_syn;
  logic              s1_advance;
  logic              in_acc;
  logic [CHK_W-1:0]  key_reg;
  logic [CHK_W-1:0]  es;
  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_chkerr;
  logic              dec_unc;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_corr_q;
  logic              out_chkerr_q;
  logic              out_unc_q;
  logic              out_hs;

  assign s1_advance   = s1_valid & (~out_valid_q | bus.out_ready);
  assign bus.in_ready = ~s1_valid | s1_advance;
  assign in_acc       = bus.in_valid & bus.in_ready;
  assign out_hs       = out_valid_q & bus.out_ready;

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_corr   = out_corr_q;
  assign bus.out_chkerr = out_chkerr_q;
  assign bus.out_unc    = out_unc_q;

  // Raw syndrome of the incoming word: received check bits against recomputed ones.
  always_comb begin
    in_syn = bus.in_chk;
    for (int j = 0; j < DATA_W; j++) begin
      if (bus.in_data[j]) in_syn = in_syn ^ COLS[j*CHK_W +: CHK_W];
    end
  end

  // Key-adjusted syndrome decode; a wrong key skews es and so the corrections.
  always_comb begin
    es         = s1_q.syn ^ key_reg ^ KEY_MASK;
    dec_data   = s1_q.data;
    dec_corr   = 1'b0;
    dec_chkerr = 1'b0;
    dec_unc    = 1'b0;
    if (s1_q.en && es != '0) begin
      if ($onehot(es)) begin
        dec_chkerr = 1'b1;
      end else begin
        dec_unc = 1'b1;
        for (int j = 0; j < DATA_W; j++) begin
          if (es == COLS[j*CHK_W +: CHK_W]) begin
            dec_data[j] = ~s1_q.data[j];
            dec_corr    = 1'b1;
            dec_unc     = 1'b0;
          end
        end
      end
    end
  end

  // Stage 1: capture accepted word with its raw syndrome; empties when it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_acc) begin
      s1_valid <= 1'b1;
      s1_q     <= '{data: bus.in_data, syn: in_syn, en: bus.in_en};
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 / output register: load on advance, hold while stalled, drop valid after handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_corr_q   <= 1'b0;
      out_chkerr_q <= 1'b0;
      out_unc_q    <= 1'b0;
    end else if (s1_advance) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= dec_data;
      out_corr_q   <= dec_corr;
      out_chkerr_q <= dec_chkerr;
      out_unc_q    <= dec_unc;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  // Serial key: new bit enters at the MSB, register shifts toward the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg <= '0;
    end else if (key_shift) begin
      key_reg <= {key_sin, key_reg[CHK_W-1:1]};
    end
  end

  // Saturating statistics per output handshake; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt <= '0;
      unc_cnt  <= '0;
    end else if (cnt_clr) begin
      corr_cnt <= '0;
      unc_cnt  <= '0;
    end else if (out_hs) begin
      if (out_corr_q && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
      if (out_unc_q  && unc_cnt  != '1) unc_cnt  <= unc_cnt  + CNT_W'(1);
    end
  end

endmodule
